pixel_sequencer: RTL and testbench

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

---
 rtl/pixel_sequencer_pkg.sv | 60 ++++++
 rtl/pixel_prog_ram.sv | 36 +++
 rtl/pixel_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pixel_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_sequencer_pkg.sv
// pixel_sequencer_pkg
// Shared definitions for the pixel sequencer and anything that decodes its
// instruction stream: instruction field layout, opcodes, register indices,
// the NOP word and the sequencer state encoding.
//
// Instruction word (49 bits, MSB first):
//   [48:45] dest  [44:41] op  [40] use_const  [39:36] src_a  [35:32] src_b  [31:0] const

package pixel_sequencer_pkg;

    localparam int INSN_W        = 49;
    localparam int REG_W         = 4;
    localparam int OP_W          = 4;
    localparam int CONST_W       = 32;

    localparam int DEST_LSB      = 45;
    localparam int OP_LSB        = 41;
    localparam int USE_CONST_BIT = 40;
    localparam int SRC_A_LSB     = 36;
    localparam int SRC_B_LSB     = 32;
    localparam int CONST_LSB     = 0;

    localparam logic [OP_W-1:0] OP_MOV = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR = 4'd5;
    localparam logic [OP_W-1:0] OP_MUL = 4'd6;
    localparam logic [OP_W-1:0] OP_SHL = 4'd7;
    localparam logic [OP_W-1:0] OP_SHR = 4'd8;

    localparam logic [REG_W-1:0] REG_X      = 4'd8;
    localparam logic [REG_W-1:0] REG_Y      = 4'd9;
    localparam logic [REG_W-1:0] REG_F      = 4'd10;
    localparam logic [REG_W-1:0] REG_RESULT = 4'd11;
    localparam logic [REG_W-1:0] REG_SCRATCH_NOP = 4'd15;

    // MOV r15, #0 -- harmless to the ALU, driven whenever no program word is due
    localparam logic [INSN_W-1:0] NOP_INSN =
        {REG_SCRATCH_NOP, OP_MOV, 1'b1, 4'd0, 4'd0, 32'd0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } seq_state_t;

    function automatic logic [INSN_W-1:0] make_insn(
        input logic [REG_W-1:0]   dest,
        input logic [OP_W-1:0]    op,
        input logic               use_const,
        input logic [REG_W-1:0]   src_a,
        input logic [REG_W-1:0]   src_b,
        input logic [CONST_W-1:0] imm
    );
        return {dest, op, use_const, src_a, src_b, imm};
    endfunction

endpackage

// File: rtl/pixel_prog_ram.sv
// pixel_prog_ram
// Program store for the pixel sequencer: DEPTH words of WIDTH bits,
// synchronous write and registered (one-cycle) read. Not reset, so a loaded
// program survives a sequencer reset.
//
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address, sampled on the rising edge
//   rdata  - read data, valid the cycle after raddr is sampled

module pixel_prog_ram #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 49,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pixel_sequencer.sv
// pixel_sequencer
// Walks a frame pixel by pixel in raster order. For each pixel it streams
// the loaded program (prog_len words) to a pixel ALU, then holds the pixel
// as valid until the consumer takes it.
//
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   prog_we/addr/data     - program load port, honoured only while idle
//   prog_len              - words per pixel, latched (and clamped) on start
//   start                 - request one frame
//   instruction           - word for the ALU (NOP_INSN when nothing is due)
//   x_coord/y_coord       - current pixel; f_number - frame counter
//   pixel_valid/ready     - finished-pixel handshake
//   busy, frame_done      - not idle; one-cycle end-of-frame pulse

module pixel_sequencer
    import pixel_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = 64,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [INSN_W-1:0]             prog_data,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic                          start,
    output logic [INSN_W-1:0]             instruction,
    output logic [31:0]                   x_coord,
    output logic [31:0]                   y_coord,
    output logic [31:0]                   f_number,
    output logic                          pixel_valid,
    input  logic                          pixel_ready,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int ADDR_W = $clog2(PROG_DEPTH);
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PROG_DEPTH);
    localparam logic [31:0] X_LAST = 32'(FB_WIDTH - 1);
    localparam logic [31:0] Y_LAST = 32'(FB_HEIGHT - 1);

    seq_state_t        state, state_next;
    logic              fetch_wait, fetch_wait_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  len, len_next, len_clamped;
    logic [31:0]       x_next, y_next, f_next;
    logic              frame_done_next;
    logic [INSN_W-1:0] rd_data;

    // Loads are dropped while a frame is in flight so the program stays
    // coherent with what the ALU is executing.
    pixel_prog_ram #(
        .DEPTH  (PROG_DEPTH),
        .WIDTH  (INSN_W),
        .ADDR_W (ADDR_W)
    ) u_prog_ram (
        .clk   (clk),
        .we    (prog_we && (state == ST_IDLE)),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // The RAM read is registered, so rd_addr always points at the word for
    // the next cycle. Entering from IDLE costs one bubble (fetch_wait) to
    // fetch word 0; OUT prefetches word 0 so the next pixel starts straight
    // after the handshake.
    always_comb begin
        state_next      = state;
        fetch_wait_next = fetch_wait;
        pc_next         = pc;
        len_next        = len;
        x_next          = x_coord;
        y_next          = y_coord;
        f_next          = f_number;
        frame_done_next = 1'b0;
        rd_addr         = '0;
        instruction     = NOP_INSN;
        pixel_valid     = 1'b0;
        busy            = (state != ST_IDLE);
        len_clamped     = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;

        case (state)
            ST_IDLE: begin
                if (start && (len_clamped != '0)) begin
                    state_next      = ST_RUN;
                    len_next        = len_clamped;
                    pc_next         = '0;
                    fetch_wait_next = 1'b1;
                    x_next          = '0;
                    y_next          = '0;
                end
            end
            ST_RUN: begin
                if (fetch_wait) begin
                    fetch_wait_next = 1'b0;
                end else begin
                    instruction = rd_data;
                    rd_addr     = pc + ADDR_W'(1);
                    if ({1'b0, pc} == (len - LEN_W'(1))) begin
                        state_next = ST_OUT;
                    end else begin
                        pc_next = pc + ADDR_W'(1);
                    end
                end
            end
            ST_OUT: begin
                pixel_valid = 1'b1;
                if (pixel_ready) begin
                    pc_next    = '0;
                    state_next = ST_RUN;
                    if (x_coord == X_LAST) begin
                        x_next = '0;
                        if (y_coord == Y_LAST) begin
                            y_next          = '0;
                            f_next          = f_number + 32'd1;
                            frame_done_next = 1'b1;
                            state_next      = ST_IDLE;
                        end else begin
                            y_next = y_coord + 32'd1;
                        end
                    end else begin
                        x_next = x_coord + 32'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; the program RAM is deliberately outside this reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            fetch_wait <= 1'b0;
            pc         <= '0;
            len        <= '0;
            x_coord    <= '0;
            y_coord    <= '0;
            f_number   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_wait <= fetch_wait_next;
            pc         <= pc_next;
            len        <= len_next;
            x_coord    <= x_next;
            y_coord    <= y_next;
            f_number   <= f_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_pixel_sequencer.sv
// tb_pixel_sequencer
// Self-checking bench. The main instance runs a 4x2 frame with a 16-word
// program store; the reference is a pixel-level model (raster index ->
// coordinates, word j of each pixel -> prog[j]). A second 4x1 instance
// feeds a small behavioural ALU running "MOV RESULT, X".

module tb_pixel_sequencer;
    import pixel_sequencer_pkg::*;

    localparam int DEPTH = 16;
    localparam int W     = 4;
    localparam int H     = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, prog_we, start, pixel_ready;
    logic [3:0]        prog_addr;
    logic [INSN_W-1:0] prog_data;
    logic [4:0]        prog_len;
    logic [INSN_W-1:0] instruction;
    logic [31:0]       x_coord, y_coord, f_number;
    logic              pixel_valid, busy, frame_done;

    logic              b_prog_we, b_start, b_ready;
    logic [3:0]        b_prog_addr;
    logic [INSN_W-1:0] b_prog_data;
    logic [4:0]        b_prog_len;
    logic [INSN_W-1:0] b_instruction;
    logic [31:0]       b_x, b_y, b_f;
    logic              b_valid, b_busy, b_frame_done;

    int                vectors = 0;
    int                miscompares = 0;
    int                f_exp = 0;
    logic [INSN_W-1:0] model_prog [DEPTH];
    logic [31:0]       alu_result;

    pixel_sequencer #(.PROG_DEPTH(DEPTH), .FB_WIDTH(W), .FB_HEIGHT(H)) dut (
        .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start),
        .instruction(instruction), .x_coord(x_coord), .y_coord(y_coord),
        .f_number(f_number), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .busy(busy), .frame_done(frame_done)
    );

    pixel_sequencer #(.PROG_DEPTH(DEPTH), .FB_WIDTH(4), .FB_HEIGHT(1)) dut_alu (
        .clk(clk), .reset_n(reset_n), .prog_we(b_prog_we), .prog_addr(b_prog_addr),
        .prog_data(b_prog_data), .prog_len(b_prog_len), .start(b_start),
        .instruction(b_instruction), .x_coord(b_x), .y_coord(b_y),
        .f_number(b_f), .pixel_valid(b_valid), .pixel_ready(b_ready),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    // Behavioural ALU: executes MOV into RESULT, reading X/Y/F or a constant.
    always @(posedge clk) begin
        if (b_instruction[48:45] == REG_RESULT && b_instruction[44:41] == OP_MOV) begin
            if (b_instruction[40]) begin
                alu_result <= b_instruction[31:0];
            end else begin
                case (b_instruction[39:36])
                    REG_X:   alu_result <= b_x;
                    REG_Y:   alu_result <= b_y;
                    REG_F:   alu_result <= b_f;
                    default: alu_result <= 32'd0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input logic [INSN_W-1:0] insn_exp, input logic valid_exp,
                              input int x_exp, input int y_exp, input logic busy_exp);
        checkOutput("insn",  instruction, insn_exp);
        checkOutput("valid", pixel_valid, valid_exp);
        checkOutput("x",     x_coord, x_exp);
        checkOutput("y",     y_coord, y_exp);
        checkOutput("f",     f_number, f_exp);
        checkOutput("busy",  busy, busy_exp);
    endtask

    // Load one program word while idle and mirror it into the model.
    task automatic applyStimulus(input int addr, input logic [INSN_W-1:0] data);
        prog_we   = 1'b1;
        prog_addr = 4'(addr);
        prog_data = data;
        tick();
        prog_we   = 1'b0;
        model_prog[addr] = data;
    endtask

    // One frame: stall_pixel/stall_cycles hold pixel_ready low at that pixel,
    // stop_pixel (>=0) applies reset while that pixel is being offered.
    task automatic runFrame(input int len_req, input int stall_pixel,
                            input int stall_cycles, input int stop_pixel);
        int len_eff;
        int valid_count;
        logic [63:0] rnd;
        len_eff     = (len_req > DEPTH) ? DEPTH : len_req;
        valid_count = 0;
        prog_len    = 5'(len_req);
        pixel_ready = 1'b1;
        start       = 1'b1;
        tick();
        checkState(NOP_INSN, 1'b0, 0, 0, 1'b1);
        prog_len = 5'($urandom_range(0, 31));
        for (int k = 0; k < W * H; k++) begin
            if (k == 1) start = 1'b0;
            for (int j = 0; j < len_eff; j++) begin
                if (k == 1 && j == 0) begin
                    rnd       = {$urandom(), $urandom()};
                    prog_we   = 1'b1;
                    prog_addr = 4'd2;
                    prog_data = rnd[INSN_W-1:0];
                end
                tick();
                prog_we = 1'b0;
                checkState(model_prog[j], 1'b0, k % W, k / W, 1'b1);
            end
            if (k == stall_pixel) pixel_ready = 1'b0;
            tick();
            checkState(NOP_INSN, 1'b1, k % W, k / W, 1'b1);
            if (pixel_valid) valid_count++;
            if (k == stall_pixel) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    tick();
                    checkState(NOP_INSN, 1'b1, k % W, k / W, 1'b1);
                end
                pixel_ready = 1'b1;
            end
            if (k == stop_pixel) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
                f_exp   = 0;
                checkState(NOP_INSN, 1'b0, 0, 0, 1'b0);
                checkOutput("rst_frame_done", frame_done, 1'b0);
                return;
            end
        end
        tick();
        f_exp++;
        checkState(NOP_INSN, 1'b0, 0, 0, 1'b0);
        checkOutput("frame_done_pulse", frame_done, 1'b1);
        checkOutput("valid_pulses", valid_count, W * H);
        tick();
        checkOutput("frame_done_clear", frame_done, 1'b0);
        checkState(NOP_INSN, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        logic [63:0] rnd;
        int captured;
        reset_n = 1'b0; prog_we = 1'b0; start = 1'b0; pixel_ready = 1'b1;
        prog_addr = '0; prog_data = '0; prog_len = '0;
        b_prog_we = 1'b0; b_start = 1'b0; b_ready = 1'b1;
        b_prog_addr = '0; b_prog_data = '0; b_prog_len = '0;
        tick();
        tick();
        reset_n = 1'b1;
        $display("[TB] reset state");
        checkState(NOP_INSN, 1'b0, 0, 0, 1'b0);
        checkOutput("reset_frame_done", frame_done, 1'b0);

        for (int a = 0; a < DEPTH; a++) begin
            rnd = {$urandom(), $urandom()};
            applyStimulus(a, rnd[INSN_W-1:0]);
        end

        $display("[TB] zero-length program is ignored");
        prog_len = 5'd0;
        start    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("len0_busy", busy, 1'b0);
            checkOutput("len0_insn", instruction, NOP_INSN);
        end
        start = 1'b0;

        $display("[TB] full frame, three words per pixel");
        runFrame(3, -1, 0, -1);
        $display("[TB] consumer stall at pixel (1,0)");
        runFrame(3, 1, 5, -1);
        $display("[TB] random length and stall");
        runFrame(int'($urandom_range(1, 6)), int'($urandom_range(0, W * H - 1)),
                 int'($urandom_range(1, 4)), -1);
        $display("[TB] oversize length clamps to depth");
        runFrame(31, -1, 0, -1);
        $display("[TB] reset at pixel (2,1)");
        runFrame(3, -1, 0, 6);
        $display("[TB] program survives reset");
        runFrame(3, -1, 0, -1);

        $display("[TB] sequencer driving ALU with MOV RESULT, X");
        b_prog_we   = 1'b1;
        b_prog_addr = 4'd0;
        b_prog_data = make_insn(REG_RESULT, OP_MOV, 1'b0, REG_X, 4'd0, 32'd0);
        tick();
        b_prog_we  = 1'b0;
        b_prog_len = 5'd1;
        b_start    = 1'b1;
        tick();
        b_start  = 1'b0;
        captured = 0;
        for (int c = 0; c < 40 && captured < 4; c++) begin
            tick();
            if (b_valid) begin
                checkOutput("alu_result", alu_result, captured);
                captured++;
            end
        end
        checkOutput("alu_pixels", captured, 4);
        tick();
        checkOutput("alu_idle", b_busy, 1'b0);
        checkOutput("alu_frame", b_f, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
